// File: rtl/branch_hazard_ctrl.sv
// branch_hazard_ctrl: ID-stage branch hazard stall/flush controller; optional perf counters via BRANCH_HAZARD_PERF_EN
module branch_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [31:0]      ID_Instruction,
    input  logic             EX_RegWrite,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_WriteReg,
    input  logic             MEM_MemRead,
    input  logic [4:0]       MEM_WriteReg,
    input  logic             PCSel,
    output logic             Stall_PC,
    output logic             Stall_IFID,
    output logic             Bubble_IDEX,
    output logic             Flush_IFID,
    output logic [1:0]       State
`ifdef BRANCH_HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] StallCycleCnt,
    output logic [CNT_W-1:0] RedirectCnt
`endif
);
    typedef enum logic [1:0] {IDLE = 2'b00, STALL = 2'b01, FLUSH = 2'b10} state_t;
    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] need;
    logic       stall, flush;
    logic [5:0] opcode, funct;
    logic [4:0] rs, rt;
    logic       is_ctrl, uses_rt;
    logic       unused_instr_bits;
    assign opcode            = ID_Instruction[31:26];
    assign rs                = ID_Instruction[25:21];
    assign rt                = ID_Instruction[20:16];
    assign funct             = ID_Instruction[5:0];
    assign unused_instr_bits = ^ID_Instruction[15:6];
    assign uses_rt = (opcode == 6'b000100) || (opcode == 6'b000101);
    assign is_ctrl = (opcode == 6'b000001) || (opcode[5:2] == 4'b0001) ||
                     (opcode == 6'b000000 && funct == 6'b001000);
    function automatic logic src_hit(input logic [4:0] r);
        return (r != 5'd0) && ((r == rs) || (uses_rt && r == rt));
    endfunction
    // Cycles the branch in ID must wait for its operands to become forwardable
    always_comb begin
        need = 2'd0;
        if (is_ctrl)
            need = (EX_MemRead && src_hit(EX_WriteReg))   ? 2'd2 :
                   (EX_RegWrite && src_hit(EX_WriteReg))  ? 2'd1 :
                   (MEM_MemRead && src_hit(MEM_WriteReg)) ? 2'd1 : 2'd0;
    end
    // Next-state and raw stall/flush decisions; stall wins over redirect
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        flush   = 1'b0;
        case (state_q)
            IDLE: begin
                if (need != 2'd0) begin
                    stall = 1'b1;
                    if (need == 2'd2) begin
                        state_d = STALL;
                        cnt_d   = need - 2'd1;
                    end
                end else if (PCSel) begin
                    flush   = 1'b1;
                    state_d = FLUSH;
                end
            end
            STALL: begin
                stall   = 1'b1;
                cnt_d   = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
                state_d = (cnt_q <= 2'd1) ? IDLE : STALL;
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // State and stall counter registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    assign Stall_PC    = stall & ~Rst;
    assign Stall_IFID  = stall & ~Rst;
    assign Bubble_IDEX = stall & ~Rst;
    assign Flush_IFID  = flush & ~Rst;
    assign State       = Rst ? IDLE : state_q;
`ifdef BRANCH_HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, redir_cnt_q;
    // Saturating counts of stall cycles and redirect flushes
    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (stall && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (flush && !(&redir_cnt_q)) redir_cnt_q <= redir_cnt_q + 1'b1;
        end
    end
    assign StallCycleCnt = stall_cnt_q;
    assign RedirectCnt   = redir_cnt_q;
`else
    localparam int unused_cnt_w = CNT_W;
`endif
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb_branch_hazard_ctrl: directed checks of stall/flush sequencing (perf counters when BRANCH_HAZARD_PERF_EN)
module tb_branch_hazard_ctrl;
    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [31:0] ID_Instruction = '0;
    logic        EX_RegWrite = 0, EX_MemRead = 0, MEM_MemRead = 0, PCSel = 0;
    logic [4:0]  EX_WriteReg = '0, MEM_WriteReg = '0;
    logic        Stall_PC, Stall_IFID, Bubble_IDEX, Flush_IFID;
    logic [1:0]  State;
    logic [3:0]  outs;
    int          errors = 0, checks = 0;
`ifdef BRANCH_HAZARD_PERF_EN
    logic [3:0]  StallCycleCnt, RedirectCnt;
`endif
    localparam logic [31:0] BEQ_8_9  = {6'b000100, 5'd8, 5'd9, 16'd0};
    localparam logic [31:0] BNE_0_8  = {6'b000101, 5'd0, 5'd8, 16'd0};
    localparam logic [31:0] BEQ_3_3  = {6'b000100, 5'd3, 5'd3, 16'd0};
    localparam logic [31:0] BGTZ_0   = {6'b000111, 5'd0, 5'd0, 16'd0};
    localparam logic [31:0] BLEZ_RT8 = {6'b000110, 5'd0, 5'd8, 16'd0};
    localparam logic [31:0] BLTZ_8   = {6'b000001, 5'd8, 5'd0, 16'd0};
    localparam logic [31:0] JR_31    = {6'b000000, 5'd31, 15'd0, 6'b001000};
    localparam logic [31:0] J_RS8    = {6'b000010, 5'd8, 21'd0};
    localparam logic [31:0] ADD_8_9  = {6'b000000, 5'd8, 5'd9, 5'd10, 5'd0, 6'b100000};

    always #5 Clk = ~Clk;
    assign outs = {Stall_PC, Stall_IFID, Bubble_IDEX, Flush_IFID};

    branch_hazard_ctrl #(.CNT_W(4)) dut (
        .Clk(Clk), .Rst(Rst), .ID_Instruction(ID_Instruction),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_WriteReg(EX_WriteReg),
        .MEM_MemRead(MEM_MemRead), .MEM_WriteReg(MEM_WriteReg), .PCSel(PCSel),
        .Stall_PC(Stall_PC), .Stall_IFID(Stall_IFID), .Bubble_IDEX(Bubble_IDEX),
        .Flush_IFID(Flush_IFID), .State(State)
`ifdef BRANCH_HAZARD_PERF_EN
        , .StallCycleCnt(StallCycleCnt), .RedirectCnt(RedirectCnt)
`endif
    );

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic exrw, input logic exmr,
                         input logic [4:0] exwr, input logic memmr, input logic [4:0] memwr,
                         input logic pcsel);
        ID_Instruction = ins;
        EX_RegWrite    = exrw;
        EX_MemRead     = exmr;
        EX_WriteReg    = exwr;
        MEM_MemRead    = memmr;
        MEM_WriteReg   = memwr;
        PCSel          = pcsel;
        #1;
    endtask

    task automatic test_reset;
        tick;
        tick;
        drive(BEQ_8_9, 1, 1, 5'd8, 0, 5'd0, 1);
        checks++; if (outs !== 4'b0000) begin errors++; $display("FAIL rst_outs got=%b want=0000", outs); end
        checks++; if (State !== 2'b00) begin errors++; $display("FAIL rst_state got=%b want=00", State); end
        Rst = 1'b0;
        #1;
        checks++; if (outs !== 4'b1110) begin errors++; $display("FAIL post_rst_eval got=%b want=1110", outs); end
        drive('0, 0, 0, 5'd0, 0, 5'd0, 0);
        checks++; if (outs !== 4'b0000) begin errors++; $display("FAIL post_rst_idle got=%b want=0000", outs); end
        tick;
        checks++; if (State !== 2'b00) begin errors++; $display("FAIL post_rst_state got=%b want=00", State); end
    endtask

    task automatic test_load_use;
        drive(BEQ_8_9, 1, 1, 5'd8, 0, 5'd0, 0);
        checks++; if (outs !== 4'b1110) begin errors++; $display("FAIL lu_c1 got=%b want=1110", outs); end
        checks++; if (State !== 2'b00) begin errors++; $display("FAIL lu_c1_state got=%b want=00", State); end
        tick;
        PCSel = 1'b1;
        #1;
        checks++; if (State !== 2'b01) begin errors++; $display("FAIL lu_c2_state got=%b want=01", State); end
        checks++; if (outs !== 4'b1110) begin errors++; $display("FAIL lu_c2 got=%b want=1110", outs); end
        tick;
        checks++; if (State !== 2'b00) begin errors++; $display("FAIL lu_c3_state got=%b want=00", State); end
        drive('0, 0, 0, 5'd0, 0, 5'd0, 0);
        checks++; if (outs !== 4'b0000) begin errors++; $display("FAIL lu_c3 got=%b want=0000", outs); end
    endtask

    task automatic test_alu_use;
        drive(BNE_0_8, 1, 0, 5'd8, 0, 5'd0, 1);
        checks++; if (outs !== 4'b1110) begin errors++; $display("FAIL alu_c1 got=%b want=1110", outs); end
        tick;
        checks++; if (State !== 2'b00) begin errors++; $display("FAIL alu_state got=%b want=00", State); end
        drive(BLTZ_8, 0, 0, 5'd0, 1, 5'd8, 0);
        checks++; if (outs !== 4'b1110) begin errors++; $display("FAIL mem_load got=%b want=1110", outs); end
        tick;
        checks++; if (State !== 2'b00) begin errors++; $display("FAIL mem_load_state got=%b want=00", State); end
        drive(JR_31, 1, 1, 5'd31, 0, 5'd0, 0);
        checks++; if (outs !== 4'b1110) begin errors++; $display("FAIL jr_c1 got=%b want=1110", outs); end
        tick;
        checks++; if (State !== 2'b01) begin errors++; $display("FAIL jr_state got=%b want=01", State); end
        tick;
        drive('0, 0, 0, 5'd0, 0, 5'd0, 0);
        checks++; if (State !== 2'b00) begin errors++; $display("FAIL jr_back got=%b want=00", State); end
    endtask

    task automatic test_flush;
        drive(BEQ_3_3, 0, 0, 5'd0, 0, 5'd0, 1);
        checks++; if (outs !== 4'b0001) begin errors++; $display("FAIL flush_c1 got=%b want=0001", outs); end
        tick;
        drive(BEQ_3_3, 1, 1, 5'd3, 0, 5'd0, 1);
        checks++; if (State !== 2'b10) begin errors++; $display("FAIL flush_state got=%b want=10", State); end
        checks++; if (outs !== 4'b0000) begin errors++; $display("FAIL flush_masked got=%b want=0000", outs); end
        tick;
        checks++; if (State !== 2'b00) begin errors++; $display("FAIL flush_back got=%b want=00", State); end
        drive('0, 0, 0, 5'd0, 0, 5'd0, 0);
    endtask

    task automatic test_no_stall;
        drive(BGTZ_0, 1, 0, 5'd0, 0, 5'd0, 0);
        checks++; if (outs !== 4'b0000) begin errors++; $display("FAIL reg0 got=%b want=0000", outs); end
        drive(J_RS8, 1, 1, 5'd8, 0, 5'd0, 0);
        checks++; if (outs !== 4'b0000) begin errors++; $display("FAIL jump got=%b want=0000", outs); end
        drive(ADD_8_9, 1, 1, 5'd8, 1, 5'd9, 0);
        checks++; if (outs !== 4'b0000) begin errors++; $display("FAIL nonctrl got=%b want=0000", outs); end
        drive(BLEZ_RT8, 1, 0, 5'd8, 0, 5'd0, 0);
        checks++; if (outs !== 4'b0000) begin errors++; $display("FAIL blez_rt got=%b want=0000", outs); end
        tick;
        checks++; if (State !== 2'b00) begin errors++; $display("FAIL nostall_state got=%b want=00", State); end
        drive('0, 0, 0, 5'd0, 0, 5'd0, 0);
    endtask

    task automatic test_rst_mid_stall;
        drive(BEQ_8_9, 1, 1, 5'd8, 0, 5'd0, 0);
        tick;
        Rst = 1'b1;
        #1;
        checks++; if (outs !== 4'b0000) begin errors++; $display("FAIL rst_stall_outs got=%b want=0000", outs); end
        tick;
        drive('0, 0, 0, 5'd0, 0, 5'd0, 0);
        Rst = 1'b0;
        #1;
        checks++; if (State !== 2'b00) begin errors++; $display("FAIL rst_stall_state got=%b want=00", State); end
        checks++; if (outs !== 4'b0000) begin errors++; $display("FAIL rst_stall_after got=%b want=0000", outs); end
`ifdef BRANCH_HAZARD_PERF_EN
        checks++; if (StallCycleCnt !== 4'd0) begin errors++; $display("FAIL rst_stallcnt got=%0d want=0", StallCycleCnt); end
        checks++; if (RedirectCnt !== 4'd0) begin errors++; $display("FAIL rst_redircnt got=%0d want=0", RedirectCnt); end
`endif
        drive(BEQ_3_3, 0, 0, 5'd0, 0, 5'd0, 1);
        tick;
        drive('0, 0, 0, 5'd0, 0, 5'd0, 0);
        Rst = 1'b1;
        #1;
        checks++; if (State !== 2'b00) begin errors++; $display("FAIL rst_flush_state got=%b want=00", State); end
        tick;
        Rst = 1'b0;
        #1;
        checks++; if (State !== 2'b00) begin errors++; $display("FAIL rst_flush_after got=%b want=00", State); end
    endtask

`ifdef BRANCH_HAZARD_PERF_EN
    task automatic test_perf;
        Rst = 1'b1;
        tick;
        Rst = 1'b0;
        #1;
        checks++; if (StallCycleCnt !== 4'd0) begin errors++; $display("FAIL perf_init got=%0d want=0", StallCycleCnt); end
        drive(BEQ_3_3, 0, 0, 5'd0, 0, 5'd0, 1);
        tick;
        drive('0, 0, 0, 5'd0, 0, 5'd0, 0);
        tick;
        checks++; if (RedirectCnt !== 4'd1) begin errors++; $display("FAIL perf_redir got=%0d want=1", RedirectCnt); end
        drive(BNE_0_8, 1, 0, 5'd8, 0, 5'd0, 0);
        repeat (5) tick;
        checks++; if (StallCycleCnt !== 4'd5) begin errors++; $display("FAIL perf_stall5 got=%0d want=5", StallCycleCnt); end
        repeat (15) tick;
        drive('0, 0, 0, 5'd0, 0, 5'd0, 0);
        checks++; if (StallCycleCnt !== 4'd15) begin errors++; $display("FAIL perf_sat got=%0d want=15", StallCycleCnt); end
        checks++; if (RedirectCnt !== 4'd1) begin errors++; $display("FAIL perf_redir_hold got=%0d want=1", RedirectCnt); end
    endtask
`endif

    initial begin
        test_reset;
        test_load_use;
        test_alu_use;
        test_flush;
        test_no_stall;
        test_rst_mid_stall;
`ifdef BRANCH_HAZARD_PERF_EN
        test_perf;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
